data_bus_responder: RTL and testbench
=====================================

Name: data_bus_responder

Overview:
- Word-addressed data-memory responder for the CPU data bus (cs, wr_rd, ADDR, Data_BUS_WRITE in; Data_BUS_READ out).
- Services CPU load/store traffic with a fixed, parameterised read latency, since the bus has no ready/wait signal.
- Flags out-of-range and misaligned accesses, and counts accesses for bench and debug visibility.
- Sits between the cpu data-bus ports and the top-level/testbench.

Parameters:
- ADDR_BITS, 8, log2 of memory depth in 32-bit words (256 words).
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 2^(ADDR_BITS+2).
- READ_LAT, 1, read latency in clock edges; legal range 1..4.
- ERR_DATA, 32'hDEAD_BEEF, value returned for an erroneous read.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  chip select; an access is sampled when high at a rising edge.
- wr_rd  input  1  1 = write, 0 = read; qualified by cs.
- ADDR  input  32  byte address.
- Data_BUS_WRITE  input  32  write data.
- Data_BUS_READ  output  32  read data; registered.
- rd_valid  output  1  one-cycle pulse marking Data_BUS_READ as new read data.
- err  output  1  sticky; set on any bad access.
- rd_count  output  16  completed reads, saturating.
- wr_count  output  16  accepted writes, saturating.

Behaviour:
- Reset (async assert, sync release):
  - Data_BUS_READ = 0, rd_valid = 0, err = 0, rd_count = 0, wr_count = 0.
  - Read pipeline flushed.
  - Memory array is NOT cleared; contents are undefined until written.
- Decode:
  - Word index = ADDR[ADDR_BITS+1:2].
  - In-range = ADDR[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2].
  - Aligned = ADDR[1:0] == 2'b00.
  - Good = in-range AND aligned.
- Write (cs=1, wr_rd=1 at edge N):
  - Good: mem[index] = Data_BUS_WRITE at edge N; wr_count increments.
  - Bad: memory unchanged, err set, wr_count unchanged.
  - Writes never produce rd_valid.
- Read (cs=1, wr_rd=0 at edge N):
  - Request enters a READ_LAT-deep shift pipeline carrying a valid bit, the index and a bad flag.
  - Memory is read at issue (edge N), not at retirement.
  - At edge N+READ_LAT: Data_BUS_READ = mem[index] (or ERR_DATA if bad), rd_valid = 1 for exactly one cycle, rd_count increments.
  - A bad read sets err at edge N.
- Back-to-back:
  - One access may be accepted every cycle; reads retire in order, one per cycle.
  - With READ_LAT=1, Data_BUS_READ updates on every cycle in which a read retires.
- Read-after-write:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
  - A read and a write cannot share a cycle (single wr_rd), so no same-cycle hazard exists.
- Idle (cs=0): no state change apart from in-flight reads advancing.
- Data_BUS_READ holds its last value while rd_valid = 0.
- err is cleared only by reset.
- Counters saturate at 16'hFFFF; no wrap.
- Reset mid-read: in-flight reads are discarded; no rd_valid pulse after reset deassertion, and rd_count does not count them.
- wr_rd/ADDR/Data_BUS_WRITE are don't-care when cs=0.

Test Plan:
- Reset, then write 32'h1234_5678 to ADDR 0x10, then read 0x10 (READ_LAT=1) -> rd_valid pulse one edge after the read, Data_BUS_READ = 32'h1234_5678, wr_count = 1, rd_count = 1, err = 0.
- Write 0xA5A5_A5A5 to 0x3FC, read 0x3FC the very next cycle -> 0xA5A5_A5A5 returned; then read 0x400 (out of range) -> Data_BUS_READ = 32'hDEAD_BEEF with rd_valid, err = 1 and staying 1.
- Misaligned write to 0x11 with data 0xFFFF_FFFF -> mem[4] unchanged (subsequent read of 0x10 returns the prior value), err = 1, wr_count not incremented.
- READ_LAT=3, reads of 0x0, 0x4, 0x8 on consecutive cycles holding 1, 2, 3 -> rd_valid high on edges N+3, N+4, N+5 with data 1, 2, 3 in order.
- READ_LAT=3, assert reset one cycle after a read issue -> all outputs 0 immediately (async); no rd_valid after release; rd_count = 0.
- Preload the counter via 65,540 good writes -> wr_count = 16'hFFFF and holds.

Source files
------------

// File: rtl/data_bus_responder.sv
// Word-addressed data memory on the CPU data bus.
// Fixed-latency reads, sticky error flag, saturating access counters.
module data_bus_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  output logic [31:0] Data_BUS_READ,
  output logic        rd_valid,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic                 in_rng;
  logic                 aligned;
  logic                 good;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [31:0]          rd_word;

  assign idx     = ADDR[ADDR_BITS+1:2];
  assign in_rng  = ADDR[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
  assign aligned = ADDR[1:0] == 2'b00;
  assign good    = in_rng & aligned;
  assign wr_acc  = cs & wr_rd;
  assign rd_acc  = cs & ~wr_rd;
  // Array is read at issue; the pipe only carries the result to retirement.
  assign rd_word = good ? mem[idx] : ERR_DATA;

  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [31:0]         dat_q [READ_LAT];
  logic [31:0]         dat_d [READ_LAT];
  logic [31:0]         rdata_q, rdata_d;
  logic                rvld_q, rvld_d;
  logic                err_q, err_d;
  logic [15:0]         rd_cnt_q, rd_cnt_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d;

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_acc;
    dat_d[0] = rd_word;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    rvld_d   = vld_q[READ_LAT-1];
    rdata_d  = rvld_d ? dat_q[READ_LAT-1] : rdata_q;
    err_d    = err_q | (cs & ~good);
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rvld_d && rd_cnt_q != 16'hFFFF)
      rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_acc && good && wr_cnt_q != 16'hFFFF)
      wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      dat_q    <= '{default: '0};
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      rdata_q  <= rdata_d;
      rvld_q   <= rvld_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_acc && good)
      mem[idx] <= Data_BUS_WRITE;
  end

  assign Data_BUS_READ = rdata_q;
  assign rd_valid      = rvld_q;
  assign err           = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder.
// Two instances: READ_LAT=1 and READ_LAT=3.
module tb_data_bus_responder;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst1, cs1, wr1;
  logic [31:0] a1, wd1, rd1;
  logic        v1, e1;
  logic [15:0] rc1, wc1;

  logic        rst3, cs3, wr3;
  logic [31:0] a3, wd3, rd3;
  logic        v3, e3;
  logic [15:0] rc3, wc3;

  int n_chk = 0;
  int n_err = 0;

  data_bus_responder #(.READ_LAT(1)) u_l1 (
    .CLK(CLK), .reset(rst1), .cs(cs1), .wr_rd(wr1),
    .ADDR(a1), .Data_BUS_WRITE(wd1), .Data_BUS_READ(rd1),
    .rd_valid(v1), .err(e1), .rd_count(rc1), .wr_count(wc1)
  );

  data_bus_responder #(.READ_LAT(3)) u_l3 (
    .CLK(CLK), .reset(rst3), .cs(cs3), .wr_rd(wr3),
    .ADDR(a3), .Data_BUS_WRITE(wd3), .Data_BUS_READ(rd3),
    .rd_valid(v3), .err(e3), .rd_count(rc3), .wr_count(wc3)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic drv1(input logic c, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    cs1 = c; wr1 = w; a1 = a; wd1 = d;
  endtask

  task automatic drv3(input logic c, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    cs3 = c; wr3 = w; a3 = a; wd3 = d;
  endtask

  logic        ev [7];
  logic [31:0] ed [7];

  initial begin
    rst1 = 0; rst3 = 0;
    cs1 = 0; wr1 = 0; a1 = 0; wd1 = 0;
    cs3 = 0; wr3 = 0; a3 = 0; wd3 = 0;
    #1 rst1 = 1; rst3 = 1;
    #2;
    check("rst_rdata", rd1, 32'h0);
    check("rst_vld",   {31'b0, v1}, 32'h0);
    check("rst_err",   {31'b0, e1}, 32'h0);
    check("rst_rdcnt", {16'b0, rc1}, 32'h0);
    check("rst_wrcnt", {16'b0, wc1}, 32'h0);
    @(negedge CLK);
    rst1 = 0;

    // write then read 0x10
    drv1(1, 1, 32'h10, 32'h1234_5678);
    drv1(0, 0, 0, 0);
    drv1(1, 0, 32'h10, 0);
    drv1(0, 0, 0, 0);
    check("t1_early_vld", {31'b0, v1}, 32'h0);
    drv1(0, 0, 0, 0);
    check("t1_vld",   {31'b0, v1}, 32'h1);
    check("t1_data",  rd1, 32'h1234_5678);
    check("t1_wrcnt", {16'b0, wc1}, 32'h1);
    check("t1_rdcnt", {16'b0, rc1}, 32'h1);
    check("t1_err",   {31'b0, e1}, 32'h0);
    drv1(0, 0, 0, 0);
    check("t1_pulse_end", {31'b0, v1}, 32'h0);
    check("t1_hold", rd1, 32'h1234_5678);

    // RAW at top word, then out-of-range read
    drv1(1, 1, 32'h3FC, 32'hA5A5_A5A5);
    drv1(1, 0, 32'h3FC, 0);
    drv1(1, 0, 32'h400, 0);
    drv1(0, 0, 0, 0);
    check("t2_raw_vld",  {31'b0, v1}, 32'h1);
    check("t2_raw_data", rd1, 32'hA5A5_A5A5);
    check("t2_err_set",  {31'b0, e1}, 32'h1);
    drv1(0, 0, 0, 0);
    check("t2_oor_vld",  {31'b0, v1}, 32'h1);
    check("t2_oor_data", rd1, 32'hDEAD_BEEF);
    check("t2_rdcnt",    {16'b0, rc1}, 32'h3);
    drv1(0, 0, 0, 0);
    check("t2_vld_low",  {31'b0, v1}, 32'h0);
    check("t2_err_stk",  {31'b0, e1}, 32'h1);

    // misaligned write must not touch mem[4]
    drv1(1, 1, 32'h11, 32'hFFFF_FFFF);
    drv1(1, 0, 32'h10, 0);
    drv1(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    check("t3_vld",   {31'b0, v1}, 32'h1);
    check("t3_data",  rd1, 32'h1234_5678);
    check("t3_wrcnt", {16'b0, wc1}, 32'h2);
    check("t3_err",   {31'b0, e1}, 32'h1);

    // READ_LAT=3 ordering
    @(negedge CLK);
    rst3 = 0;
    drv3(1, 1, 32'h0, 32'd1);
    drv3(1, 1, 32'h4, 32'd2);
    drv3(1, 1, 32'h8, 32'd3);
    drv3(1, 0, 32'h0, 0);
    ev = '{0, 0, 0, 1, 1, 1, 0};
    ed = '{0, 0, 0, 32'd1, 32'd2, 32'd3, 0};
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      drv3(1, 0, 32'h4, 0);
      else if (i == 1) drv3(1, 0, 32'h8, 0);
      else             drv3(0, 0, 0, 0);
      check($sformatf("l3_vld%0d", i), {31'b0, v3}, {31'b0, ev[i]});
      if (ev[i])
        check($sformatf("l3_dat%0d", i), rd3, ed[i]);
    end
    check("l3_rdcnt", {16'b0, rc3}, 32'h3);
    check("l3_wrcnt", {16'b0, wc3}, 32'h3);

    // reset with a read in flight
    drv3(1, 0, 32'h4, 0);
    drv3(0, 0, 0, 0);
    @(posedge CLK);
    #2 rst3 = 1;
    #1;
    check("mr_rdata", rd3, 32'h0);
    check("mr_vld",   {31'b0, v3}, 32'h0);
    check("mr_rdcnt", {16'b0, rc3}, 32'h0);
    check("mr_wrcnt", {16'b0, wc3}, 32'h0);
    @(negedge CLK);
    rst3 = 0;
    for (int i = 0; i < 5; i++) begin
      drv3(0, 0, 0, 0);
      check($sformatf("mr_novld%0d", i), {31'b0, v3}, 32'h0);
    end
    check("mr_rdcnt_post", {16'b0, rc3}, 32'h0);

    // write counter saturation
    for (int i = 0; i < 65540; i++)
      drv3(1, 1, 32'h20, i);
    drv3(0, 0, 0, 0);
    check("sat_wrcnt", {16'b0, wc3}, 32'h0000_FFFF);
    drv3(1, 1, 32'h20, 0);
    drv3(0, 0, 0, 0);
    check("sat_hold", {16'b0, wc3}, 32'h0000_FFFF);
    check("sat_err",  {31'b0, e3}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
